hls_fp32_sub_chn_in_rsci: RTL and testbench

- Input-channel interface stage for one fp32 operand channel (instantiated once each for chn_a and chn_b) of the HLS fp32 subtract core.
- Sits between the upstream valid/ready channel and the core staller.
- Buffers operands in a 2-entry skid FIFO and produces the per-channel wen_comp that the staller ANDs into core_wen.
- Pops an operand only when the whole core advances.

---
 rtl/hls_fp32_sub_pkg.sv | 7 +
 rtl/hls_fp32_sub_chn_in_rsci_if.sv | 29 ++
 rtl/hls_fp32_sub_skid2.sv | 57 +++++
 rtl/hls_fp32_sub_chn_in_rsci.sv | 53 +++++
 tb/tb_hls_fp32_sub_chn_in_rsci.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/hls_fp32_sub_pkg.sv
// Shared constants for the fp32 subtract core's channel interface stages.
package hls_fp32_sub_pkg;
  localparam int FP32_W       = 32;
  localparam int FIFO_DEPTH   = 2;
  localparam int FIFO_CNT_W   = 2;
  localparam int STARVE_CNT_W = 16;
endpackage

// File: rtl/hls_fp32_sub_chn_in_rsci_if.sv
// Bundle of the upstream valid/ready channel and the core/staller handshake for one operand channel.
interface hls_fp32_sub_chn_in_rsci_if
  import hls_fp32_sub_pkg::*;
#(
  parameter int DW  = FP32_W,
  parameter int SCW = STARVE_CNT_W
);
  // Upstream beat transfers on a rising edge where chn_rsc_vz & chn_rsc_lz; the core consumes
  // the head on an edge where core_wen & chn_rsci_oswt and the channel holds an operand.
  logic [DW-1:0]  chn_rsc_z;
  logic           chn_rsc_vz;
  logic           chn_rsc_lz;
  logic           chn_rsci_oswt;
  logic           core_wen;
  logic           core_wten;
  logic           chn_rsci_wen_comp;
  logic [DW-1:0]  chn_rsci_d_mxwt;
  logic [SCW-1:0] chn_rsci_starve_cnt;

  modport slave (
    input  chn_rsc_z, chn_rsc_vz, chn_rsci_oswt, core_wen, core_wten,
    output chn_rsc_lz, chn_rsci_wen_comp, chn_rsci_d_mxwt, chn_rsci_starve_cnt
  );

  modport master (
    output chn_rsc_z, chn_rsc_vz, chn_rsci_oswt, core_wen, core_wten,
    input  chn_rsc_lz, chn_rsci_wen_comp, chn_rsci_d_mxwt, chn_rsci_starve_cnt
  );
endinterface

// File: rtl/hls_fp32_sub_skid2.sv
// Generic 2-entry skid FIFO; ready depends only on registered occupancy and reset.
module hls_fp32_sub_skid2
  import hls_fp32_sub_pkg::*;
#(
  parameter int DW = FP32_W
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [DW-1:0]         push_data_i,
  input  logic                  push_valid_i,
  input  logic                  pop_i,
  output logic                  ready_o,
  output logic [FIFO_CNT_W-1:0] count_o,
  output logic [DW-1:0]         head_o
);
  logic [DW-1:0]         mem_q [FIFO_DEPTH];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [FIFO_CNT_W-1:0] count_q, count_d;
  logic                  push;

  // Gating ready with reset keeps a beat offered during reset from being taken.
  assign ready_o = rstn_i & (count_q != FIFO_CNT_W'(FIFO_DEPTH));
  assign push    = push_valid_i & ready_o;
  assign count_o = count_q;
  assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

  // pop_i is only asserted by the owner when the FIFO holds an entry.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop_i) rd_ptr_d = ~rd_ptr_q;
    case ({push, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= push_data_i;
  end
endmodule

// File: rtl/hls_fp32_sub_chn_in_rsci.sv
// Operand input channel stage: skid buffer, per-channel wen_comp and a starvation counter.
module hls_fp32_sub_chn_in_rsci
  import hls_fp32_sub_pkg::*;
#(
  parameter int DW  = FP32_W,
  parameter int SCW = STARVE_CNT_W
) (
  input logic                        nvdla_core_clk,
  input logic                        nvdla_core_rstn,
  hls_fp32_sub_chn_in_rsci_if.slave  chn
);
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [DW-1:0]         fifo_head;
  logic                  fifo_ready;
  logic                  fifo_empty;
  logic                  pop;
  logic                  starve_inc;
  logic [SCW-1:0]        starve_q, starve_d;

  assign fifo_empty = (fifo_count == '0);

  // An operand leaves only when the whole core advances; a stray core_wen on empty is ignored.
  assign pop = chn.core_wen & chn.chn_rsci_oswt & ~fifo_empty;

  hls_fp32_sub_skid2 #(.DW(DW)) u_skid (
    .clk_i        (nvdla_core_clk),
    .rstn_i       (nvdla_core_rstn),
    .push_data_i  (chn.chn_rsc_z),
    .push_valid_i (chn.chn_rsc_vz),
    .pop_i        (pop),
    .ready_o      (fifo_ready),
    .count_o      (fifo_count),
    .head_o       (fifo_head)
  );

  assign chn.chn_rsc_lz          = fifo_ready;
  assign chn.chn_rsci_d_mxwt     = fifo_head;
  assign chn.chn_rsci_wen_comp   = ~chn.chn_rsci_oswt | ~fifo_empty;
  assign chn.chn_rsci_starve_cnt = starve_q;

  // Post-stall bubbles (wten high, no request) must not be counted a second time.
  assign starve_inc = chn.chn_rsci_oswt & fifo_empty & ~(chn.core_wten & ~chn.chn_rsci_oswt);

  always_comb begin
    starve_d = starve_q;
    if (starve_inc && (starve_q != '1)) starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) starve_q <= '0;
    else                  starve_q <= starve_d;
  end
endmodule

// File: tb/tb_hls_fp32_sub_chn_in_rsci.sv
// Directed bench for the fp32 subtract operand input channel stage.
module tb_hls_fp32_sub_chn_in_rsci;
  localparam int DW  = 32;
  localparam int SCW = 4;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_errors;
  logic [DW-1:0] exp_q[$];

  hls_fp32_sub_chn_in_rsci_if #(.DW(DW), .SCW(SCW)) chn_if ();

  hls_fp32_sub_chn_in_rsci #(.DW(DW), .SCW(SCW)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .chn             (chn_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic vz, input logic [DW-1:0] z, input logic oswt,
                        input logic cw, input logic wten);
    chn_if.chn_rsc_vz    = vz;
    chn_if.chn_rsc_z     = z;
    chn_if.chn_rsci_oswt = oswt;
    chn_if.core_wen      = cw;
    chn_if.core_wten     = wten;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    logic [DW-1:0] v;
    n_checks = 0;
    n_errors = 0;

    // reset held with an upstream beat offered and the core requesting
    rstn = 1'b0;
    set_in(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rst_lz", chn_if.chn_rsc_lz, 0);
      check_eq("rst_wen_comp", chn_if.chn_rsci_wen_comp, 0);
      check_eq("rst_d", chn_if.chn_rsci_d_mxwt, 0);
      check_eq("rst_starve", chn_if.chn_rsci_starve_cnt, 0);
    end
    rstn = 1'b1;
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("rel_lz", chn_if.chn_rsc_lz, 1);
    check_eq("rel_wen_comp", chn_if.chn_rsci_wen_comp, 1);

    // single beat, no bypass
    set_in(1'b1, 32'h3F80_0000, 1'b1, 1'b0, 1'b0);
    #1;
    check_eq("sb_wen_n", chn_if.chn_rsci_wen_comp, 0);
    check_eq("sb_d_n", chn_if.chn_rsci_d_mxwt, 0);
    tick();
    set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
    #1;
    check_eq("sb_wen_n1", chn_if.chn_rsci_wen_comp, 1);
    check_eq("sb_d_n1", chn_if.chn_rsci_d_mxwt, 32'h3F80_0000);
    set_in(1'b0, '0, 1'b1, 1'b1, 1'b0);
    tick();
    set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
    #1;
    check_eq("sb_d_pop", chn_if.chn_rsci_d_mxwt, 0);
    check_eq("sb_wen_pop", chn_if.chn_rsci_wen_comp, 0);

    // fill and backpressure
    set_in(1'b1, 32'h1, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 32'h2, 1'b0, 1'b0, 1'b0);
    #1;
    check_eq("fill_lz_one", chn_if.chn_rsc_lz, 1);
    tick();
    set_in(1'b1, 32'h3, 1'b0, 1'b0, 1'b0);
    #1;
    check_eq("fill_lz_full", chn_if.chn_rsc_lz, 0);
    check_eq("fill_head1", chn_if.chn_rsci_d_mxwt, 32'h1);
    tick();
    check_eq("fill_lz_hold", chn_if.chn_rsc_lz, 0);
    check_eq("fill_head_hold", chn_if.chn_rsci_d_mxwt, 32'h1);
    set_in(1'b1, 32'h3, 1'b1, 1'b1, 1'b0);
    tick();
    set_in(1'b1, 32'h3, 1'b0, 1'b0, 1'b0);
    #1;
    check_eq("fill_lz_reopen", chn_if.chn_rsc_lz, 1);
    check_eq("fill_head2", chn_if.chn_rsci_d_mxwt, 32'h2);
    tick();
    exp_q.push_back(32'h2);
    exp_q.push_back(32'h3);
    set_in(1'b0, '0, 1'b1, 1'b1, 1'b0);
    while (exp_q.size() != 0) begin
      #1;
      check_eq("fill_order", chn_if.chn_rsci_d_mxwt, exp_q.pop_front());
      tick();
    end
    set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
    #1;
    check_eq("fill_empty_d", chn_if.chn_rsci_d_mxwt, 0);
    check_eq("fill_empty_wen", chn_if.chn_rsci_wen_comp, 0);

    // streaming: one operand in and one out per cycle after the first fill
    for (int i = 0; i < 100; i++) begin
      v = 32'h4000_0100 + DW'(i);
      set_in(1'b1, v, 1'b1, 1'b1, 1'b0);
      #1;
      check_eq("str_lz", chn_if.chn_rsc_lz, 1);
      if (i == 0) check_eq("str_first_wen", chn_if.chn_rsci_wen_comp, 0);
      else        check_eq("str_data", chn_if.chn_rsci_d_mxwt, exp_q.pop_front());
      exp_q.push_back(v);
      tick();
    end
    set_in(1'b0, '0, 1'b1, 1'b1, 1'b0);
    #1;
    check_eq("str_last", chn_if.chn_rsci_d_mxwt, exp_q.pop_front());
    tick();
    set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
    #1;
    check_eq("str_drained_wen", chn_if.chn_rsci_wen_comp, 0);

    // reset mid-operation with a full FIFO and a beat in flight
    set_in(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("mid_full_lz", chn_if.chn_rsc_lz, 0);
    rstn = 1'b0;
    set_in(1'b1, 32'hD, 1'b0, 1'b0, 1'b0);
    #1;
    check_eq("mid_rst_lz", chn_if.chn_rsc_lz, 0);
    tick();
    rstn = 1'b1;
    set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
    #1;
    check_eq("mid_wen", chn_if.chn_rsci_wen_comp, 0);
    check_eq("mid_d", chn_if.chn_rsci_d_mxwt, 0);
    check_eq("mid_lz", chn_if.chn_rsc_lz, 1);
    check_eq("mid_starve", chn_if.chn_rsci_starve_cnt, 0);
    set_in(1'b1, 32'hC000_0000, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
    #1;
    check_eq("mid_new_head", chn_if.chn_rsci_d_mxwt, 32'hC000_0000);
    check_eq("mid_new_wen", chn_if.chn_rsci_wen_comp, 1);
    set_in(1'b0, '0, 1'b1, 1'b1, 1'b0);
    tick();
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    check_eq("mid_no_stale", chn_if.chn_rsci_d_mxwt, 0);

    // starvation counter: post-stall bubbles, then saturation
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, '0, 1'b0, 1'b0, 1'b1);
      tick();
      check_eq("stv_wten_bubble", chn_if.chn_rsci_starve_cnt, 0);
    end
    for (int i = 0; i < 20; i++) begin
      set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
      tick();
      check_eq("stv_count", chn_if.chn_rsci_starve_cnt, (i + 1 > 15) ? 15 : i + 1);
    end
    for (int i = 0; i < 2; i++) begin
      set_in(1'b0, '0, 1'b0, 1'b0, 1'b1);
      tick();
      check_eq("stv_hold", chn_if.chn_rsci_starve_cnt, 15);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
